// File: rtl/alu_arbiter_if.sv
// Request/response channels between the two ALU requesters and alu_arbiter.
interface alu_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned SEL_WIDTH  = 5
);
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [DATA_WIDTH-1:0] req_a0;
   logic [DATA_WIDTH-1:0] req_a1;
   logic [DATA_WIDTH-1:0] req_b0;
   logic [DATA_WIDTH-1:0] req_b1;
   logic [SEL_WIDTH-1:0]  req_sel0;
   logic [SEL_WIDTH-1:0]  req_sel1;
   logic [1:0]            rsp_valid;
   logic [1:0]            rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_result0;
   logic [DATA_WIDTH-1:0] rsp_result1;

   modport master (
      output req_valid, req_a0, req_a1, req_b0, req_b1, req_sel0, req_sel1, rsp_ready,
      input  req_ready, rsp_valid, rsp_result0, rsp_result1
   );

   modport slave (
      input  req_valid, req_a0, req_a1, req_b0, req_b1, req_sel0, req_sel1, rsp_ready,
      output req_ready, rsp_valid, rsp_result0, rsp_result1
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between the execute pipe (port 0)
// and the address/branch-compare unit (port 1), with a registered response per port.
module alu_arbiter #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned SEL_WIDTH  = 5,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_arbiter_if.slave          bus,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [SEL_WIDTH-1:0]  alu_sel,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic [CNT_WIDTH-1:0]  conflict_cnt
);

   logic [1:0]            elig;
   logic [1:0]            grant;
   logic                  prio;
   logic [1:0]            rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_result0_q;
   logic [DATA_WIDTH-1:0] rsp_result1_q;

   // A slot is free when empty or being drained this same cycle.
   always_comb begin
      elig  = bus.req_valid & (~rsp_valid_q | bus.rsp_ready);
      grant = 2'b00;
      if (!rst) begin
         if (elig == 2'b11) grant = prio ? 2'b10 : 2'b01;
         else               grant = elig;
      end
   end

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_sel = '0;
      if (grant[0]) begin
         alu_a   = bus.req_a0;
         alu_b   = bus.req_b0;
         alu_sel = bus.req_sel0;
      end else if (grant[1]) begin
         alu_a   = bus.req_a1;
         alu_b   = bus.req_b1;
         alu_sel = bus.req_sel1;
      end
   end

   assign bus.req_ready   = grant;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_result0 = rsp_result0_q;
   assign bus.rsp_result1 = rsp_result1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prio          <= 1'b0;
         rsp_valid_q   <= 2'b00;
         rsp_result0_q <= '0;
         rsp_result1_q <= '0;
         conflict_cnt  <= '0;
      end else begin
         if (grant[0])      prio <= 1'b1;
         else if (grant[1]) prio <= 1'b0;

         if (grant[0]) begin
            rsp_result0_q  <= alu_result;
            rsp_valid_q[0] <= 1'b1;
         end else if (bus.rsp_ready[0]) begin
            rsp_valid_q[0] <= 1'b0;
         end

         if (grant[1]) begin
            rsp_result1_q  <= alu_result;
            rsp_valid_q[1] <= 1'b1;
         end else if (bus.rsp_ready[1]) begin
            rsp_valid_q[1] <= 1'b0;
         end

         // Saturate rather than wrap so a long-running count stays meaningful.
         if (elig == 2'b11 && conflict_cnt != {CNT_WIDTH{1'b1}})
            conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_arbiter;
   localparam int unsigned DW = 64;
   localparam int unsigned SW = 5;

   localparam logic [SW-1:0] OP_ADD  = 5'b00000;
   localparam logic [SW-1:0] OP_SUB  = 5'b00001;
   localparam logic [SW-1:0] OP_AND  = 5'b00010;
   localparam logic [SW-1:0] OP_SLT  = 5'b00101;
   localparam logic [SW-1:0] OP_ADDW = 5'b01010;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic [SW-1:0] alu_sel;
   logic [15:0]   conflict_cnt;
   logic [DW-1:0] alu_a4, alu_b4, alu_result4;
   logic [SW-1:0] alu_sel4;
   logic [3:0]    conflict_cnt4;

   int checks = 0;
   int errors = 0;

   alu_arbiter_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();
   alu_arbiter_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus4 ();

   function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [SW-1:0] sel);
      logic [31:0] w;
      w = a[31:0] + b[31:0];
      case (sel)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         OP_ADDW: return {{32{w[31]}}, w};
         default: return 64'd0;
      endcase
   endfunction

   assign alu_result  = alu_f(alu_a, alu_b, alu_sel);
   assign alu_result4 = alu_f(alu_a4, alu_b4, alu_sel4);

   // Narrow-counter copy sees identical stimulus.
   assign bus4.req_valid = bus.req_valid;
   assign bus4.req_a0    = bus.req_a0;
   assign bus4.req_a1    = bus.req_a1;
   assign bus4.req_b0    = bus.req_b0;
   assign bus4.req_b1    = bus.req_b1;
   assign bus4.req_sel0  = bus.req_sel0;
   assign bus4.req_sel1  = bus.req_sel1;
   assign bus4.rsp_ready = bus.rsp_ready;

   alu_arbiter #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .conflict_cnt(conflict_cnt)
   );

   alu_arbiter #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4.slave),
      .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4),
      .alu_result(alu_result4), .conflict_cnt(conflict_cnt4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [SW-1:0] s);
      bus.req_a0 = a; bus.req_b0 = b; bus.req_sel0 = s;
   endtask

   task automatic drive1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [SW-1:0] s);
      bus.req_a1 = a; bus.req_b1 = b; bus.req_sel1 = s;
   endtask

   initial begin
      rst = 1'b1;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b00;
      drive0(64'd0, 64'd0, OP_ADD);
      drive1(64'd0, 64'd0, OP_ADD);
      cyc();
      check("rst_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_result0", bus.rsp_result0, 64'd0);
      check("rst_result1", bus.rsp_result1, 64'd0);
      check("rst_cnt", 64'(conflict_cnt), 64'd0);

      // Single request on port 0
      rst = 1'b0;
      bus.req_valid = 2'b01;
      bus.rsp_ready = 2'b11;
      drive0(64'd5, 64'd3, OP_ADD);
      #1;
      check("t1_ready", 64'(bus.req_ready), 64'd1);
      check("t1_alu_a", alu_a, 64'd5);
      cyc();
      check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("t1_result0", bus.rsp_result0, 64'd8);
      // prio now points at port 1
      bus.req_valid = 2'b11;
      drive1(64'd9, 64'd1, OP_ADD);
      #1;
      check("t1_prio1", 64'(bus.req_ready), 64'd2);
      cyc();
      bus.req_valid = 2'b00;
      check("t1_result1", bus.rsp_result1, 64'd10);
      cyc();
      check("t1_drain", 64'(bus.rsp_valid), 64'd0);

      // Both valid after reset
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.req_valid = 2'b11;
      drive0(64'd10, 64'd4, OP_SUB);
      drive1(64'hF0, 64'h3C, OP_AND);
      #1;
      check("t2_grant0", 64'(bus.req_ready), 64'd1);
      cyc();
      check("t2_rsp_valid0", 64'(bus.rsp_valid), 64'd1);
      check("t2_result0", bus.rsp_result0, 64'd6);
      bus.req_valid = 2'b10;
      #1;
      check("t2_grant1", 64'(bus.req_ready), 64'd2);
      cyc();
      bus.req_valid = 2'b00;
      check("t2_rsp_valid1", 64'(bus.rsp_valid), 64'd2);
      check("t2_result1", bus.rsp_result1, 64'h30);
      check("t2_result0_hold", bus.rsp_result0, 64'd6);
      check("t2_cnt", 64'(conflict_cnt), 64'd1);
      cyc();
      check("t2_drain", 64'(bus.rsp_valid), 64'd0);

      // Backpressure on port 0
      bus.rsp_ready = 2'b00;
      bus.req_valid = 2'b01;
      drive0(64'd1, 64'd2, OP_ADD);
      #1;
      check("t3_ready_first", 64'(bus.req_ready), 64'd1);
      cyc();
      check("t3_result_first", bus.rsp_result0, 64'd3);
      drive0(64'h7FFFFFFF, 64'd1, OP_ADDW);
      #1;
      check("t3_blocked", 64'(bus.req_ready), 64'd0);
      cyc();
      check("t3_blocked2", 64'(bus.req_ready), 64'd0);
      check("t3_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("t3_hold_result", bus.rsp_result0, 64'd3);
      bus.rsp_ready = 2'b01;
      #1;
      check("t3_unblocked", 64'(bus.req_ready), 64'd1);
      cyc();
      bus.req_valid = 2'b00;
      check("t3_valid", 64'(bus.rsp_valid), 64'd1);
      check("t3_addw", bus.rsp_result0, 64'hFFFFFFFF80000000);
      cyc();
      check("t3_drain", 64'(bus.rsp_valid), 64'd0);

      // Back-to-back on port 0
      bus.req_valid = 2'b01;
      drive0(64'hFFFFFFFFFFFFFFFF, 64'd1, OP_SLT);
      #1;
      check("t4_ready_a", 64'(bus.req_ready), 64'd1);
      cyc();
      check("t4_valid_a", 64'(bus.rsp_valid), 64'd1);
      check("t4_slt_a", bus.rsp_result0, 64'd1);
      drive0(64'd1, 64'hFFFFFFFFFFFFFFFF, OP_SLT);
      #1;
      check("t4_ready_b", 64'(bus.req_ready), 64'd1);
      cyc();
      bus.req_valid = 2'b00;
      check("t4_valid_b", 64'(bus.rsp_valid), 64'd1);
      check("t4_slt_b", bus.rsp_result0, 64'd0);
      cyc();

      // Continuous contention: strict alternation, counter and saturation
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.rsp_ready = 2'b11;
      bus.req_valid = 2'b11;
      for (int i = 0; i < 20; i++) begin
         drive0(64'(i), 64'd1, OP_ADD);
         drive1(64'(i + 10), 64'd3, OP_SUB);
         #1;
         check($sformatf("t5_grant_%0d", i), 64'(bus.req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
         cyc();
         check($sformatf("t5_valid_%0d", i), 64'(bus.rsp_valid), (i % 2 == 0) ? 64'd1 : 64'd2);
         if (i % 2 == 0) check($sformatf("t5_r0_%0d", i), bus.rsp_result0, 64'(i + 1));
         else            check($sformatf("t5_r1_%0d", i), bus.rsp_result1, 64'(i + 7));
      end
      check("t5_cnt", 64'(conflict_cnt), 64'd20);
      check("t5_cnt_sat", 64'(conflict_cnt4), 64'd15);

      // Reset while both responses pending
      bus.rsp_ready = 2'b00;
      #1;
      check("t6_grant0", 64'(bus.req_ready), 64'd1);
      cyc();
      check("t6_both_valid", 64'(bus.rsp_valid), 64'd3);
      rst = 1'b1;
      #1;
      check("t6_ready_in_rst", 64'(bus.req_ready), 64'd0);
      cyc();
      check("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("t6_result0", bus.rsp_result0, 64'd0);
      check("t6_result1", bus.rsp_result1, 64'd0);
      check("t6_cnt", 64'(conflict_cnt), 64'd0);
      rst = 1'b0;
      bus.rsp_ready = 2'b11;
      #1;
      check("t6_prio0", 64'(bus.req_ready), 64'd1);
      cyc();
      bus.req_valid = 2'b00;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational core ALU between two requesters: port 0 is the integer execute pipe, port 1 is the address/branch-compare unit.
- Round-robin arbitration with a valid/ready request channel and a registered response channel per requester.
- Drives the ALU operand and select inputs, then captures the ALU result into a per-requester response register.
- Sits between the issue logic and the ALU instance. The ALU stays purely combinational.

Parameters:
- DATA_WIDTH, 64, operand/result width.
- SEL_WIDTH, 5, ALU operation-select width (ADD=00000, SUB=00001, AND=00010, SLT=00101, ADDW=01010).
- CNT_WIDTH, 16, width of the conflict counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester request accepted this cycle.
- req_a0, req_a1  in  DATA_WIDTH  operand a for requester 0/1.
- req_b0, req_b1  in  DATA_WIDTH  operand b for requester 0/1.
- req_sel0, req_sel1  in  SEL_WIDTH  ALU op for requester 0/1.
- rsp_valid  out  2  response valid per requester.
- rsp_ready  in  2  response consumed per requester.
- rsp_result0, rsp_result1  out  DATA_WIDTH  registered result for requester 0/1.
- alu_a, alu_b  out  DATA_WIDTH  to ALU operands.
- alu_sel  out  SEL_WIDTH  to ALU select.
- alu_result  in  DATA_WIDTH  from ALU (combinational, same cycle).
- conflict_cnt  out  CNT_WIDTH  saturating count of cycles in which both requesters were eligible.

Behaviour:
- Reset (rst=1 at clock edge): rsp_valid=00, rsp_result0/1=0, prio=0, conflict_cnt=0.
  - req_ready is combinational but is forced to 00 while rst=1.
  - Reset mid-transaction drops any pending response; nothing is replayed.
- Eligibility: elig[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]).
  - At most one outstanding result per requester.
  - A response being consumed this cycle frees its slot in the same cycle (back-to-back throughput of 1 per cycle per requester).
- Grant (combinational, one-hot or zero):
  - Only elig[i] set -> grant i.
  - Both set -> grant prio.
  - Neither set -> no grant.
- req_ready = grant. A transfer on port i occurs when req_valid[i] && req_ready[i].
- ALU drive:
  - Granted requester's a/b/sel go to alu_a/alu_b/alu_sel.
  - With no grant, alu_a=0, alu_b=0, alu_sel=0 (ADD).
- Priority pointer: on any grant to i, prio <= ~i next cycle. With no grant, prio holds.
- Response register, for each i at the clock edge:
  - Transfer on i: rsp_result_i <= alu_result, rsp_valid[i] <= 1. Latency is exactly 1 cycle from acceptance to rsp_valid.
  - Else if rsp_ready[i]: rsp_valid[i] <= 0 and rsp_result_i holds its value.
  - Simultaneous consume and new transfer on i: result is overwritten and rsp_valid[i] stays 1.
- rsp_ready[i] while rsp_valid[i]=0 has no effect.
- Requester rules (checked by the bench, not enforced by the RTL):
  - Operands and sel stay stable while valid && !ready.
  - valid does not drop before ready.
- Starvation bound: a continuously eligible requester is granted within 2 cycles.
- conflict_cnt: increments when elig == 11. Saturates at all-ones (no wrap). Cleared only by rst.
- No latches. No internal FSM beyond prio, the response registers and the counter.

Test Plan:
- Reset, then req 0 alone with a=5, b=3, sel=ADD -> req_ready=01 the same cycle; next cycle rsp_valid=01, rsp_result0=8; prio=1.
- Both valid after reset: req0 SUB 10-4, req1 AND 0xF0&0x3C -> cycle0 grants 0, cycle1 grants 1 (rsp_ready held 1). rsp_result0=6, rsp_result1=0x30. conflict_cnt=1.
- Backpressure: rsp_ready0=0 with rsp_valid0=1 and req0 valid ADDW 0x7FFFFFFF+1 -> req_ready0 stays 0. Raise rsp_ready0 -> granted that cycle; next result 0xFFFFFFFF80000000.
- Back-to-back on port 0 with rsp_ready0=1: SLT -1<1 then SLT 1<-1 on consecutive cycles -> rsp_valid0 stays 1 for two cycles with results 1 then 0.
- Both requesters continuously valid and always ready for 20 cycles -> grants alternate 0,1,0,1…; conflict_cnt=20. With CNT_WIDTH=4 the counter saturates at 15.
- Assert rst while rsp_valid=11 and both requests pending -> next cycle rsp_valid=00, results 0, prio=0, req_ready=00 during rst.
